biriscv_issue_scheduler: RTL and testbench

Dual-issue scheduler between the two decode slots and the execution units. Takes the class bits produced per slot by the decoder together with register indices, tracks outstanding long-latency destination registers in a 32-entry scoreboard, tracks divider occupancy, and decides each cycle whether slot 0, and optionally slot 1, is issued. It also keeps a dual-issue performance counter.

---
 rtl/biriscv_issue_scheduler.sv | 164 ++++++++++++++++
 tb/tb_biriscv_issue_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_issue_scheduler.sv
// ---------------------------------------------------------------------------
// biriscv_issue_scheduler
//
// Dual-issue scheduler sitting between the two decode slots and the execution
// units. Each cycle it decides whether slot 0 issues and, if so, whether
// slot 1 may issue alongside it.
//
// State held:
//   - a pending-write scoreboard (one bit per architectural register) for
//     long-latency results (load, multiply, divide),
//   - divider occupancy,
//   - a free-running count of dual-issue cycles.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   slotN_valid_i            slot N holds an instruction
//   slotN_class_i[6:0]       {rd_valid, csr, div, mul, branch, lsu, exec}
//   slotN_rd/rs1/rs2_i       register indices
//   stall_i, flush_i         suppress issue while high
//   wb_{lsu,mul,div}_*       writebacks that retire pending registers
//   issue0_o, issue1_o       combinational issue decisions for this cycle
//   div_busy_o, sb_empty_o   registered divider / scoreboard status
//   dual_cnt_o               number of cycles in which both slots issued
// ---------------------------------------------------------------------------
module biriscv_issue_scheduler #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slot0_valid_i,
  input  logic [6:0]  slot0_class_i,
  input  logic [4:0]  slot0_rd_i,
  input  logic [4:0]  slot0_rs1_i,
  input  logic [4:0]  slot0_rs2_i,
  input  logic        slot1_valid_i,
  input  logic [6:0]  slot1_class_i,
  input  logic [4:0]  slot1_rd_i,
  input  logic [4:0]  slot1_rs1_i,
  input  logic [4:0]  slot1_rs2_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        wb_lsu_valid_i,
  input  logic [4:0]  wb_lsu_rd_i,
  input  logic        wb_mul_valid_i,
  input  logic [4:0]  wb_mul_rd_i,
  input  logic        wb_div_valid_i,
  input  logic [4:0]  wb_div_rd_i,
  output logic        issue0_o,
  output logic        issue1_o,
  output logic        div_busy_o,
  output logic        sb_empty_o,
  output logic [31:0] dual_cnt_o
);

  localparam int CLS_LSU = 1;
  localparam int CLS_BR  = 2;
  localparam int CLS_MUL = 3;
  localparam int CLS_DIV = 4;
  localparam int CLS_CSR = 5;
  localparam int CLS_RDV = 6;

  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                div_busy_q, div_busy_d;
  logic [31:0]         dual_cnt_q, dual_cnt_d;

  logic [NUM_REGS-1:0] clr_s, set_s, pend_s;
  logic                haz0_s, haz1_s, pair_ok_s;
  logic                issue0_s, issue1_s;
  logic                unused_s;

  // The exec class bit needs no special handling: exec results are bypassed.
  assign unused_s = ^{slot0_class_i[0], slot1_class_i[0]};

  // Register hazard against the effective pending set; x0 never hazards.
  function automatic logic reg_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic rd_valid,
                                      input logic [NUM_REGS-1:0] pend);
    logic h;
    h = 1'b0;
    if ((rs1 != 5'd0) && pend[rs1]) h = 1'b1;
    if ((rs2 != 5'd0) && pend[rs2]) h = 1'b1;
    if (rd_valid && (rd != 5'd0) && pend[rd]) h = 1'b1;
    return h;
  endfunction

  // Only loads, multiplies and divides are tracked; other results are bypassed.
  function automatic logic tracks_rd(input logic [6:0] cls, input logic [4:0] rd);
    return cls[CLS_RDV] && (rd != 5'd0) &&
           (cls[CLS_LSU] || cls[CLS_MUL] || cls[CLS_DIV]);
  endfunction

  // Issue decision, scoreboard and counter next-state.
  always_comb begin
    clr_s = {NUM_REGS{1'b0}};
    if (wb_lsu_valid_i) clr_s[wb_lsu_rd_i] = 1'b1;
    if (wb_mul_valid_i) clr_s[wb_mul_rd_i] = 1'b1;
    if (wb_div_valid_i) clr_s[wb_div_rd_i] = 1'b1;

    // Writebacks landing this cycle are bypassed, so they no longer block.
    pend_s = sb_q & ~clr_s;

    haz0_s = reg_hazard(slot0_rs1_i, slot0_rs2_i, slot0_rd_i, slot0_class_i[CLS_RDV], pend_s);
    haz1_s = reg_hazard(slot1_rs1_i, slot1_rs2_i, slot1_rd_i, slot1_class_i[CLS_RDV], pend_s);

    // CSR (and faults routed as CSR) serialise on the registered state only.
    issue0_s = rst_ni && slot0_valid_i && !stall_i && !flush_i && !haz0_s &&
               !(slot0_class_i[CLS_DIV] && div_busy_q) &&
               !(slot0_class_i[CLS_CSR] && !((sb_q == {NUM_REGS{1'b0}}) && !div_busy_q));

    pair_ok_s = !slot1_class_i[CLS_CSR] && !slot1_class_i[CLS_DIV] &&
                !slot0_class_i[CLS_CSR] &&
                !(slot1_class_i[CLS_MUL] && slot0_class_i[CLS_MUL]) &&
                !(slot1_class_i[CLS_LSU] && slot0_class_i[CLS_LSU]) &&
                !(slot1_class_i[CLS_BR]  && slot0_class_i[CLS_BR]);
    // Intra-pair dependency on slot 0's destination.
    if (slot0_class_i[CLS_RDV] && (slot0_rd_i != 5'd0) &&
        ((slot1_rs1_i == slot0_rd_i) || (slot1_rs2_i == slot0_rd_i) ||
         (slot1_rd_i == slot0_rd_i))) begin
      pair_ok_s = 1'b0;
    end else begin
      pair_ok_s = pair_ok_s;
    end

    issue1_s = issue0_s && slot1_valid_i && !haz1_s && pair_ok_s;

    set_s = {NUM_REGS{1'b0}};
    if (issue0_s && tracks_rd(slot0_class_i, slot0_rd_i)) set_s[slot0_rd_i] = 1'b1;
    if (issue1_s && tracks_rd(slot1_class_i, slot1_rd_i)) set_s[slot1_rd_i] = 1'b1;

    // Set wins over a same-cycle clear of the same index.
    sb_d    = (sb_q & ~clr_s) | set_s;
    sb_d[0] = 1'b0;

    if (issue0_s && slot0_class_i[CLS_DIV]) begin
      div_busy_d = 1'b1;
    end else if (wb_div_valid_i) begin
      div_busy_d = 1'b0;
    end else begin
      div_busy_d = div_busy_q;
    end

    dual_cnt_d = dual_cnt_q + {31'd0, (issue0_s && issue1_s)};
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q       <= {NUM_REGS{1'b0}};
      div_busy_q <= 1'b0;
      dual_cnt_q <= 32'd0;
    end else begin
      sb_q       <= sb_d;
      div_busy_q <= div_busy_d;
      dual_cnt_q <= dual_cnt_d;
    end
  end

  assign issue0_o   = issue0_s;
  assign issue1_o   = issue1_s;
  assign div_busy_o = div_busy_q;
  assign sb_empty_o = (sb_q == {NUM_REGS{1'b0}});
  assign dual_cnt_o = dual_cnt_q;

endmodule

// File: tb/tb_biriscv_issue_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for biriscv_issue_scheduler. Directed sequences followed by random
// traffic; a reference model built on a per-register pending array predicts
// every cycle's outputs into a queue that a negedge monitor drains.
// ---------------------------------------------------------------------------
module tb_biriscv_issue_scheduler;

  localparam int RDV = 6;
  localparam int CSR = 5;
  localparam int DIV = 4;
  localparam int MUL = 3;
  localparam int BR  = 2;
  localparam int LSU = 1;

  localparam logic [6:0] C_EXEC = 7'b1000001;
  localparam logic [6:0] C_LSU  = 7'b1000010;
  localparam logic [6:0] C_BR   = 7'b0000100;
  localparam logic [6:0] C_MUL  = 7'b1001000;
  localparam logic [6:0] C_DIV  = 7'b1010000;
  localparam logic [6:0] C_CSR  = 7'b1100000;

  typedef struct {
    logic       v0, v1;
    logic [6:0] c0, c1;
    logic [4:0] rd0, rs10, rs20, rd1, rs11, rs21;
    logic       stall, flush;
    logic       lv, mv, dv;
    logic [4:0] lr, mr, dr;
  } stim_t;

  typedef struct {
    logic        i0, i1, sbe, db;
    logic [31:0] cnt;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        slot0_valid_i, slot1_valid_i;
  logic [6:0]  slot0_class_i, slot1_class_i;
  logic [4:0]  slot0_rd_i, slot0_rs1_i, slot0_rs2_i;
  logic [4:0]  slot1_rd_i, slot1_rs1_i, slot1_rs2_i;
  logic        stall_i, flush_i;
  logic        wb_lsu_valid_i, wb_mul_valid_i, wb_div_valid_i;
  logic [4:0]  wb_lsu_rd_i, wb_mul_rd_i, wb_div_rd_i;
  logic        issue0_o, issue1_o, div_busy_o, sb_empty_o;
  logic [31:0] dual_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state.
  bit        m_pend[32];
  bit        m_div;
  bit [31:0] m_dual;

  always #5 clk_i = ~clk_i;

  biriscv_issue_scheduler #(.NUM_REGS(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slot0_valid_i(slot0_valid_i), .slot0_class_i(slot0_class_i),
    .slot0_rd_i(slot0_rd_i), .slot0_rs1_i(slot0_rs1_i), .slot0_rs2_i(slot0_rs2_i),
    .slot1_valid_i(slot1_valid_i), .slot1_class_i(slot1_class_i),
    .slot1_rd_i(slot1_rd_i), .slot1_rs1_i(slot1_rs1_i), .slot1_rs2_i(slot1_rs2_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_lsu_valid_i(wb_lsu_valid_i), .wb_lsu_rd_i(wb_lsu_rd_i),
    .wb_mul_valid_i(wb_mul_valid_i), .wb_mul_rd_i(wb_mul_rd_i),
    .wb_div_valid_i(wb_div_valid_i), .wb_div_rd_i(wb_div_rd_i),
    .issue0_o(issue0_o), .issue1_o(issue1_o), .div_busy_o(div_busy_o),
    .sb_empty_o(sb_empty_o), .dual_cnt_o(dual_cnt_o)
  );

  function automatic stim_t idle();
    stim_t s;
    s.v0 = 1'b0; s.v1 = 1'b0; s.c0 = 7'd0; s.c1 = 7'd0;
    s.rd0 = 5'd0; s.rs10 = 5'd0; s.rs20 = 5'd0;
    s.rd1 = 5'd0; s.rs11 = 5'd0; s.rs21 = 5'd0;
    s.stall = 1'b0; s.flush = 1'b0;
    s.lv = 1'b0; s.mv = 1'b0; s.dv = 1'b0;
    s.lr = 5'd0; s.mr = 5'd0; s.dr = 5'd0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    slot0_valid_i = s.v0; slot0_class_i = s.c0;
    slot0_rd_i = s.rd0; slot0_rs1_i = s.rs10; slot0_rs2_i = s.rs20;
    slot1_valid_i = s.v1; slot1_class_i = s.c1;
    slot1_rd_i = s.rd1; slot1_rs1_i = s.rs11; slot1_rs2_i = s.rs21;
    stall_i = s.stall; flush_i = s.flush;
    wb_lsu_valid_i = s.lv; wb_lsu_rd_i = s.lr;
    wb_mul_valid_i = s.mv; wb_mul_rd_i = s.mr;
    wb_div_valid_i = s.dv; wb_div_rd_i = s.dr;
  endtask

  // A register blocks an instruction if it is awaiting a result that is not
  // being written back in this very cycle.
  function automatic bit blocks(input int r, input stim_t s);
    if (r == 0) return 1'b0;
    if (s.lv && (int'(s.lr) == r)) return 1'b0;
    if (s.mv && (int'(s.mr) == r)) return 1'b0;
    if (s.dv && (int'(s.dr) == r)) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_div  = 1'b0;
    m_dual = 32'd0;
  endfunction

  function automatic exp_t model_expect(input stim_t s, input logic rst);
    exp_t e;
    bit   empty, h0, h1;
    int   npend;
    npend = 0;
    foreach (m_pend[i]) npend += int'(m_pend[i]);
    empty = (npend == 0);
    h0 = blocks(s.rs10, s) || blocks(s.rs20, s) || (s.c0[RDV] && blocks(s.rd0, s));
    h1 = blocks(s.rs11, s) || blocks(s.rs21, s) || (s.c1[RDV] && blocks(s.rd1, s));
    e.i0 = rst && s.v0 && !s.stall && !s.flush && !h0;
    if (s.c0[DIV] && m_div) e.i0 = 1'b0;
    if (s.c0[CSR] && (!empty || m_div)) e.i0 = 1'b0;
    e.i1 = e.i0 && s.v1 && !h1;
    if (s.c1[CSR] || s.c1[DIV] || s.c0[CSR]) e.i1 = 1'b0;
    if (s.c1[MUL] && s.c0[MUL]) e.i1 = 1'b0;
    if (s.c1[LSU] && s.c0[LSU]) e.i1 = 1'b0;
    if (s.c1[BR] && s.c0[BR]) e.i1 = 1'b0;
    if (s.c0[RDV] && s.rd0 != 5'd0 &&
        (s.rs11 == s.rd0 || s.rs21 == s.rd0 || s.rd1 == s.rd0)) e.i1 = 1'b0;
    e.sbe = empty;
    e.db  = m_div;
    e.cnt = m_dual;
    return e;
  endfunction

  function automatic void model_update(input stim_t s, input bit i0, input bit i1);
    if (s.lv) m_pend[s.lr] = 1'b0;
    if (s.mv) m_pend[s.mr] = 1'b0;
    if (s.dv) m_pend[s.dr] = 1'b0;
    if (i0 && s.c0[RDV] && s.rd0 != 5'd0 && (s.c0[LSU] || s.c0[MUL] || s.c0[DIV]))
      m_pend[s.rd0] = 1'b1;
    if (i1 && s.c1[RDV] && s.rd1 != 5'd0 && (s.c1[LSU] || s.c1[MUL] || s.c1[DIV]))
      m_pend[s.rd1] = 1'b1;
    m_pend[0] = 1'b0;
    if (i0 && s.c0[DIV]) m_div = 1'b1;
    else if (s.dv)       m_div = 1'b0;
    if (i0 && i1) m_dual = m_dual + 32'd1;
  endfunction

  // Entered and left at posedge+1.
  task automatic run_cycle(input stim_t s);
    exp_t e;
    apply(s);
    e = model_expect(s, rst_ni);
    exp_q.push_back(e);
    @(posedge clk_i);
    if (rst_ni) model_update(s, e.i0, e.i1);
    #1;
  endtask

  task automatic reset_cycle(input stim_t s);
    rst_ni = 1'b0;
    model_reset();
    run_cycle(s);
    rst_ni = 1'b1;
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endfunction

  // Monitor: pop one expectation per stimulated cycle and compare mid-cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("issue0",   {31'd0, issue0_o},   {31'd0, e.i0});
      check("issue1",   {31'd0, issue1_o},   {31'd0, e.i1});
      check("sb_empty", {31'd0, sb_empty_o}, {31'd0, e.sbe});
      check("div_busy", {31'd0, div_busy_o}, {31'd0, e.db});
      check("dual_cnt", dual_cnt_o, e.cnt);
    end
  end

  function automatic logic [6:0] rand_class();
    int k;
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1, 2, 3: return C_EXEC;
      4:          return C_BR;
      5, 6:       return C_LSU;
      7:          return C_MUL;
      8:          return C_DIV;
      default:    return C_CSR;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.v0 = ($urandom_range(0, 9) != 0);
    s.v1 = ($urandom_range(0, 3) != 0);
    s.c0 = rand_class(); s.c1 = rand_class();
    s.rd0 = 5'($urandom_range(0, 7)); s.rs10 = 5'($urandom_range(0, 7)); s.rs20 = 5'($urandom_range(0, 7));
    s.rd1 = 5'($urandom_range(0, 7)); s.rs11 = 5'($urandom_range(0, 7)); s.rs21 = 5'($urandom_range(0, 7));
    s.stall = ($urandom_range(0, 9) == 0);
    s.flush = ($urandom_range(0, 19) == 0);
    s.lv = ($urandom_range(0, 2) == 0); s.lr = 5'($urandom_range(0, 7));
    s.mv = ($urandom_range(0, 3) == 0); s.mr = 5'($urandom_range(0, 7));
    s.dv = m_div ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
    s.dr = 5'($urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    stim_t s;
    apply(idle());
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    reset_cycle(idle());

    // ADD x1 / ADDI x2: independent pair dual-issues; counter shows it next cycle.
    s = idle(); s.v0 = 1'b1; s.c0 = C_EXEC; s.rd0 = 5'd1;
    s.v1 = 1'b1; s.c1 = C_EXEC; s.rd1 = 5'd2; s.rs11 = 5'd0;
    run_cycle(s);
    run_cycle(idle());

    // LW x5 then dependent ADD x6,x5,x7: blocked until the load writes back.
    s = idle(); s.v0 = 1'b1; s.c0 = C_LSU; s.rd0 = 5'd5; s.rs10 = 5'd2;
    run_cycle(s);
    s = idle(); s.v0 = 1'b1; s.c0 = C_EXEC; s.rd0 = 5'd6; s.rs10 = 5'd5; s.rs20 = 5'd7;
    run_cycle(s);
    run_cycle(s);
    s.lv = 1'b1; s.lr = 5'd5;
    run_cycle(s);
    run_cycle(idle());

    // MUL pair: only slot 0. ADD x8 + SUB x9,x8,x1: intra-pair RAW.
    s = idle(); s.v0 = 1'b1; s.c0 = C_MUL; s.rd0 = 5'd3; s.v1 = 1'b1; s.c1 = C_MUL; s.rd1 = 5'd4;
    run_cycle(s);
    s = idle(); s.v0 = 1'b1; s.c0 = C_EXEC; s.rd0 = 5'd8;
    s.v1 = 1'b1; s.c1 = C_EXEC; s.rd1 = 5'd9; s.rs11 = 5'd8; s.rs21 = 5'd1;
    s.mv = 1'b1; s.mr = 5'd3;
    run_cycle(s);
    s = idle(); s.mv = 1'b1; s.mr = 5'd4;
    run_cycle(s);

    // DIV x10, second DIV blocked through the writeback cycle, issues after.
    s = idle(); s.v0 = 1'b1; s.c0 = C_DIV; s.rd0 = 5'd10;
    run_cycle(s);
    s.rd0 = 5'd11;
    run_cycle(s);
    run_cycle(s);
    s.dv = 1'b1; s.dr = 5'd10;
    run_cycle(s);
    s.dv = 1'b0;
    run_cycle(s);
    s = idle(); s.dv = 1'b1; s.dr = 5'd11;
    run_cycle(s);

    // CSRRW waits for an empty scoreboard; flush/stall suppress issue.
    s = idle(); s.v0 = 1'b1; s.c0 = C_LSU; s.rd0 = 5'd5;
    run_cycle(s);
    s = idle(); s.v0 = 1'b1; s.c0 = C_CSR; s.rd0 = 5'd1;
    run_cycle(s);
    s.lv = 1'b1; s.lr = 5'd5;
    run_cycle(s);
    s.lv = 1'b0;
    run_cycle(s);
    s = idle(); s.v0 = 1'b1; s.c0 = C_MUL; s.rd0 = 5'd12; s.flush = 1'b1;
    run_cycle(s);
    s.flush = 1'b0; s.stall = 1'b1;
    run_cycle(s);
    run_cycle(idle());

    // Counter wrap: preload all-ones, one dual issue returns it to zero.
    force dut.dual_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.dual_cnt_q;
    m_dual = 32'hFFFF_FFFF;
    s = idle(); s.v0 = 1'b1; s.c0 = C_EXEC; s.rd0 = 5'd1;
    s.v1 = 1'b1; s.c1 = C_BR; s.rs11 = 5'd2;
    run_cycle(s);
    run_cycle(idle());

    // Reset mid-load: pending state vanishes; the late writeback is ignored.
    s = idle(); s.v0 = 1'b1; s.c0 = C_LSU; s.rd0 = 5'd13;
    run_cycle(s);
    reset_cycle(idle());
    s = idle(); s.lv = 1'b1; s.lr = 5'd13; s.v0 = 1'b1; s.c0 = C_EXEC; s.rs10 = 5'd13;
    run_cycle(s);

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_cycle(rand_stim());
      else run_cycle(rand_stim());
    end

    apply(idle());
    repeat (3) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
